// File: rtl/frv_wide_writeback.sv
// frv_wide_writeback: accepts a 64-bit functional-unit result and sequences it
// onto the single 32-bit GPR write port. Narrow results take one write. Wide
// results take two writes to an even/odd register pair. Execute is
// back-pressured while a writeback is in progress.
module frv_wide_writeback #(
    parameter bit HI_FIRST = 1'b0,  // wide: write odd (high) register first
    parameter bit SKIP_X0  = 1'b1   // suppress writes to x0, still sequence them
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        fu_valid,
    output logic        fu_ready,
    input  logic [63:0] fu_result,
    input  logic        fu_wide,
    input  logic [4:0]  fu_rd,
    output logic        gpr_wen,
    output logic [4:0]  gpr_addr,
    output logic [31:0] gpr_wdata,
    input  logic        gpr_ready,
    output logic        wb_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_1 = 2'd1,
        WR_2 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] res_q, res_d;
    logic [4:0]  rd_q, rd_d;
    logic        wide_q, wide_d;

    logic [4:0]  addr_lo, addr_hi;
    logic        suppress;
    logic        handshake;
    logic        final_wr;
    logic        accept;

    // Pair addresses ignore rd[0]; the pair is always even/odd aligned.
    assign addr_lo = {rd_q[4:1], 1'b0};
    assign addr_hi = {rd_q[4:1], 1'b1};

    // Select the address/data for the current write from the captured result.
    always_comb begin
        gpr_addr  = 5'd0;
        gpr_wdata = 32'd0;
        case (state_q)
            WR_1: begin
                if (!wide_q) begin
                    gpr_addr  = rd_q;
                    gpr_wdata = res_q[31:0];
                end else if (HI_FIRST) begin
                    gpr_addr  = addr_hi;
                    gpr_wdata = res_q[63:32];
                end else begin
                    gpr_addr  = addr_lo;
                    gpr_wdata = res_q[31:0];
                end
            end
            WR_2: begin
                if (HI_FIRST) begin
                    gpr_addr  = addr_lo;
                    gpr_wdata = res_q[31:0];
                end else begin
                    gpr_addr  = addr_hi;
                    gpr_wdata = res_q[63:32];
                end
            end
            default: begin
                gpr_addr  = 5'd0;
                gpr_wdata = 32'd0;
            end
        endcase
    end

    // Write enable, handshake and result-interface ready.
    always_comb begin
        suppress  = SKIP_X0 && (gpr_addr == 5'd0);
        // A flush in WR_1 aborts the write; in WR_2 the first half is already
        // committed, so the second half must still go out.
        gpr_wen   = ((state_q == WR_1) && !flush && !suppress) ||
                    ((state_q == WR_2) && !suppress);
        handshake = (state_q != IDLE) && (gpr_ready || suppress);
        final_wr  = ((state_q == WR_1) && !wide_q) || (state_q == WR_2);
        fu_ready  = !flush && ((state_q == IDLE) || (final_wr && handshake));
        accept    = fu_valid && fu_ready;
        wb_busy   = (state_q != IDLE);
    end

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rd_d    = rd_q;
        wide_d  = wide_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = WR_1;
            end
            WR_1: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    if (wide_q)      state_d = WR_2;
                    else if (accept) state_d = WR_1;
                    else             state_d = IDLE;
                end
            end
            WR_2: begin
                if (handshake) state_d = accept ? WR_1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            res_d  = fu_result;
            rd_d   = fu_rd;
            wide_d = fu_wide;
        end else if ((state_q == WR_1) && flush) begin
            res_d  = 64'd0;
            rd_d   = 5'd0;
            wide_d = 1'b0;
        end
    end

    // State and captured-result registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            res_q   <= 64'd0;
            rd_q    <= 5'd0;
            wide_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            wide_q  <= wide_d;
        end
    end

endmodule

// File: tb/tb_frv_wide_writeback.sv
// Directed bench for frv_wide_writeback (HI_FIRST=0, SKIP_X0=1): a per-cycle
// vector table plus hand-written reset sequences.
module tb_frv_wide_writeback;

    logic        g_clk;
    logic        g_resetn;
    logic        flush;
    logic        fu_valid;
    logic        fu_ready;
    logic [63:0] fu_result;
    logic        fu_wide;
    logic [4:0]  fu_rd;
    logic        gpr_wen;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_wdata;
    logic        gpr_ready;
    logic        wb_busy;

    int vectors = 0;
    int miscompares = 0;

    frv_wide_writeback #(.HI_FIRST(1'b0), .SKIP_X0(1'b1)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_result (fu_result),
        .fu_wide   (fu_wide),
        .fu_rd     (fu_rd),
        .gpr_wen   (gpr_wen),
        .gpr_addr  (gpr_addr),
        .gpr_wdata (gpr_wdata),
        .gpr_ready (gpr_ready),
        .wb_busy   (wb_busy)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    typedef struct {
        logic        v;
        logic [63:0] res;
        logic        wide;
        logic [4:0]  rd;
        logic        fl;
        logic        gr;
        logic        e_rdy;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic v, input logic [63:0] res, input logic wide,
                       input logic [4:0] rd, input logic fl, input logic gr,
                       input logic e_rdy, input logic e_wen, input logic [4:0] e_addr,
                       input logic [31:0] e_data, input logic e_busy);
        vec_t t;
        t.v = v; t.res = res; t.wide = wide; t.rd = rd; t.fl = fl; t.gr = gr;
        t.e_rdy = e_rdy; t.e_wen = e_wen; t.e_addr = e_addr;
        t.e_data = e_data; t.e_busy = e_busy;
        vt.push_back(t);
    endtask

    // Idle cycle with gpr_ready high: expect IDLE outputs.
    task automatic add_idle();
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic wen,
                           input logic [4:0] addr, input logic [31:0] data, input logic busy);
        vectors++;
        chk({tag, ".fu_ready"},  {63'd0, fu_ready}, {63'd0, rdy});
        chk({tag, ".gpr_wen"},   {63'd0, gpr_wen},  {63'd0, wen});
        chk({tag, ".gpr_addr"},  {59'd0, gpr_addr}, {59'd0, addr});
        chk({tag, ".gpr_wdata"}, {32'd0, gpr_wdata}, {32'd0, data});
        chk({tag, ".wb_busy"},   {63'd0, wb_busy},  {63'd0, busy});
    endtask

    task automatic idle_inputs();
        fu_valid  = 1'b0;
        fu_result = 64'd0;
        fu_wide   = 1'b0;
        fu_rd     = 5'd0;
        flush     = 1'b0;
        gpr_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        g_resetn = 1'b0;

        // narrow rd=5
        add(1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
        add_idle();
        // wide rd=7: low word to 6, then high word to 7
        add(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h9ABC_DEF0, 1'b1);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
        add_idle();
        // back-to-back narrow to rd=1,2,3
        add(1'b1, 64'h11, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b1, 64'h22, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11, 1'b1);
        add(1'b1, 64'h33, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h22, 1'b1);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 1'b1);
        add_idle();
        // wide rd=10, stall 3 cycles in WR_2 (fu_valid held to show no accept)
        add(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b1, 64'h55, 1'b0, 5'd20, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'hCCCC_DDDD, 1'b1);
        add(1'b1, 64'h55, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hAAAA_BBBB, 1'b1);
        add(1'b1, 64'h55, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hAAAA_BBBB, 1'b1);
        add(1'b1, 64'h55, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hAAAA_BBBB, 1'b1);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'hAAAA_BBBB, 1'b1);
        add_idle();
        // flush in WR_1 of wide rd=4: no write, IDLE next
        add(1'b1, 64'h4444_4444_5555_5555, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h5555_5555, 1'b1);
        add_idle();
        // flush in IDLE: result not accepted
        add(1'b1, 64'h99, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        add_idle();
        // flush in WR_2 of wide rd=12: high write still completes
        add(1'b1, 64'h0000_00CC_0000_00BB, 1'b1, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 32'hBB, 1'b1);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'hCC, 1'b1);
        add_idle();
        // narrow rd=0: suppressed, acknowledged even with gpr_ready low
        add(1'b1, 64'h77, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h77, 1'b1);
        add_idle();
        // wide rd=0: only x1 written
        add(1'b1, 64'h0000_0001_0000_0002, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h2, 1'b1);
        add(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1, 1'b1);
        add_idle();

        // reset state while reset is held
        #12;
        chk_all("reset_hold", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        chk_all("reset_release", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge g_clk);
            fu_valid  = vt[i].v;
            fu_result = vt[i].res;
            fu_wide   = vt[i].wide;
            fu_rd     = vt[i].rd;
            flush     = vt[i].fl;
            gpr_ready = vt[i].gr;
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_wen,
                    vt[i].e_addr, vt[i].e_data, vt[i].e_busy);
        end

        // asynchronous reset in WR_2 of wide rd=14
        @(negedge g_clk);
        fu_valid = 1'b1; fu_wide = 1'b1; fu_rd = 5'd14;
        fu_result = 64'hFEED_0001_CAFE_0002; gpr_ready = 1'b1; flush = 1'b0;
        @(negedge g_clk);
        idle_inputs();
        #1;
        chk_all("arst_wr1", 1'b0, 1'b1, 5'd14, 32'hCAFE_0002, 1'b1);
        @(negedge g_clk);
        #1;
        chk_all("arst_wr2", 1'b1, 1'b1, 5'd15, 32'hFEED_0001, 1'b1);
        #1;
        g_resetn = 1'b0;
        #1;
        chk_all("arst_mid", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        chk_all("arst_after", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        // block still works after the aborted sequence
        @(negedge g_clk);
        fu_valid = 1'b1; fu_rd = 5'd3; fu_result = 64'h99;
        @(negedge g_clk);
        idle_inputs();
        #1;
        chk_all("arst_resume", 1'b1, 1'b1, 5'd3, 32'h99, 1'b1);
        @(negedge g_clk);
        #1;
        chk_all("arst_idle", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
